// File: rtl/alu_pkg.sv
// Shared definitions for the two-port shared ALU: widths, opcodes and FSM encoding.
package alu_pkg;

    localparam int DATA_W = 64;
    localparam int OP_W   = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone valid requester wins, a tie goes to
// the requester that did not win last time.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    // Tie-break against the previous winner; otherwise pick whichever is valid.
    always_comb begin
        any = |valid;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = valid[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One 64-bit ALU shared by two requesters with round-robin arbitration and a
// single operation in flight: accept -> EXEC -> RESP -> IDLE.
//
// Handshakes: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both 1; a response transfers on a rising edge where
// rsp_valid[i] and rsp_ready[i] are both 1. req_ready is a combinational
// function of req_valid, so requesters must not derive req_valid from
// req_ready. Once raised, rsp_valid/rsp_data/rsp_err hold until the owner
// takes the response.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [OP_W-1:0]   req_op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output state_t            dbg_state
);

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;

    logic              grant;
    logic              any_valid;
    logic              accept;
    logic [DATA_W-1:0] alu_res;
    logic              alu_err;

    rr_pick2 u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any_valid)
    );

    assign dbg_state = state;
    assign accept    = |(req_valid & req_ready);

    // Offer ready only to the picked requester, only while idle and out of reset.
    always_comb begin
        req_ready = 2'b00;
        if (!reset && state == IDLE && any_valid) begin
            req_ready[grant] = 1'b1;
        end
    end

    // The shared ALU, evaluated on the captured operands; unknown opcodes flag err.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            ALU_AND: alu_res = a_q & b_q;
            ALU_OR:  alu_res = a_q | b_q;
            ALU_ADD: alu_res = a_q + b_q;
            ALU_SUB: alu_res = a_q + ~b_q + {{(DATA_W-1){1'b0}}, 1'b1};
            ALU_NOR: alu_res = ~(a_q | b_q);
            default: alu_err = 1'b1;
        endcase
    end

    // Control FSM with registered operands, owner and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= grant ? req_a1  : req_a0;
                        b_q        <= grant ? req_b1  : req_b0;
                        op_q       <= grant ? req_op1 : req_op0;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_res;
                    rsp_err   <= alu_err;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for the shared-ALU arbiter: inputs change 1ns after a rising
// edge (or on a falling edge), outputs are compared on the falling edge.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]  req_op0, req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
    state_t      dbg_state;

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_op0   (req_op0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        req_a0 = 64'd1; req_b0 = 64'd2; req_op0 = ALU_ADD;
        req_a1 = 64'd3; req_b1 = 64'd4; req_op1 = ALU_ADD;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_data !== 64'd0) begin failures++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One isolated transaction on one port with immediate response acceptance.
    task automatic single_txn(input string name, input int port, input logic [63:0] a,
                              input logic [63:0] b, input logic [3:0] op,
                              input logic [63:0] exp_d, input logic exp_e);
        logic [1:0] mask;
        mask = (port == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        if (port == 1) begin req_a1 = a; req_b1 = b; req_op1 = op; end
        else begin req_a0 = a; req_b0 = b; req_op0 = op; end
        req_valid = mask;
        @(negedge clk);
        checks++; if (req_ready !== mask) begin failures++; $display("FAIL %s_req_ready: got %b expected %b", name, req_ready, mask); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_a0 = 64'hDEAD; req_b0 = 64'hBEEF; req_op0 = ALU_OR;
        req_a1 = 64'hDEAD; req_b1 = 64'hBEEF; req_op1 = ALU_OR;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL %s_early_valid: got %b expected 00", name, rsp_valid); end
        checks++; if (dbg_state !== EXEC) begin failures++; $display("FAIL %s_exec_state: got %0d expected 1", name, dbg_state); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== mask) begin failures++; $display("FAIL %s_rsp_valid: got %b expected %b", name, rsp_valid, mask); end
        checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL %s_rsp_data: got %h expected %h", name, rsp_data, exp_d); end
        checks++; if (rsp_err !== exp_e) begin failures++; $display("FAIL %s_rsp_err: got %b expected %b", name, rsp_err, exp_e); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL %s_after_hs_valid: got %b expected 00", name, rsp_valid); end
        checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL %s_hold_data: got %h expected %h", name, rsp_data, exp_d); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL %s_idle_state: got %0d expected 0", name, dbg_state); end
    endtask

    task automatic test_add();
        single_txn("add", 0, 64'd5, 64'd7, ALU_ADD, 64'd12, 1'b0);
    endtask

    task automatic test_sub();
        single_txn("sub", 1, 64'd3, 64'd5, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    endtask

    task automatic test_err_nor();
        single_txn("bad_op", 0, 64'hFFFF, 64'hFFFF, 4'b0111, 64'd0, 1'b1);
        single_txn("nor", 1, 64'd0, 64'd0, ALU_NOR, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    endtask

    task automatic test_drop();
        @(posedge clk); #1;
        req_valid = 2'b10;
        #2;
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL drop_state: got %0d expected 0", dbg_state); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL drop_rsp_valid: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_own [4];
        logic [63:0] exp_dat [4];
        bit found;
        exp_own[0] = 2'b01; exp_own[1] = 2'b10; exp_own[2] = 2'b01; exp_own[3] = 2'b10;
        exp_dat[0] = 64'h30; exp_dat[1] = 64'hFF; exp_dat[2] = 64'h30; exp_dat[3] = 64'hFF;
        apply_reset();
        rsp_ready = 2'b11;
        req_a0 = 64'hF0; req_b0 = 64'h3C; req_op0 = ALU_AND;
        req_a1 = 64'hF0; req_b1 = 64'h0F; req_op1 = ALU_OR;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            found = 1'b0;
            for (int cyc = 0; cyc < 10 && !found; cyc++) begin
                @(negedge clk);
                checks++; if (req_ready === 2'b11) begin failures++; $display("FAIL fair_ready_both: got %b expected not 11", req_ready); end
                if (rsp_valid !== 2'b00) found = 1'b1;
            end
            checks++; if (!found) begin failures++; $display("FAIL fair_timeout_%0d: got no response expected one within 10 cycles", n); end
            checks++; if (rsp_valid !== exp_own[n]) begin failures++; $display("FAIL fair_owner_%0d: got %b expected %b", n, rsp_valid, exp_own[n]); end
            checks++; if (rsp_data !== exp_dat[n]) begin failures++; $display("FAIL fair_data_%0d: got %h expected %h", n, rsp_data, exp_dat[n]); end
        end
        req_valid = 2'b00;
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        req_a0 = 64'd100; req_b0 = 64'd1; req_op0 = ALU_SUB;
        req_valid = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_req_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_a0 = 64'd0;
        req_a1 = 64'd1; req_b1 = 64'd2; req_op1 = ALU_ADD;
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_exec_ready: got %b expected 00", req_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_rsp_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_data !== 64'd99) begin failures++; $display("FAIL bp_rsp_data: got %h expected %h", rsp_data, 64'd99); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rsp_ready = (i == 1) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_hold_valid_%0d: got %b expected 01", i, rsp_valid); end
            checks++; if (rsp_data !== 64'd99) begin failures++; $display("FAIL bp_hold_data_%0d: got %h expected %h", i, rsp_data, 64'd99); end
            checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL bp_hold_err_%0d: got %b expected 0", i, rsp_err); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_hold_ready_%0d: got %b expected 00", i, req_ready); end
        end
        rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL bp_done_valid: got %b expected 00", rsp_valid); end
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_ready: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (dbg_state !== EXEC) begin failures++; $display("FAIL bp_next_exec: got %0d expected 1", dbg_state); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL bp_next_valid: got %b expected 10", rsp_valid); end
        checks++; if (rsp_data !== 64'd3) begin failures++; $display("FAIL bp_next_data: got %h expected %h", rsp_data, 64'd3); end
        @(posedge clk);
    endtask

    task automatic test_reset_in_resp();
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        req_a0 = 64'd5; req_b0 = 64'd7; req_op0 = ALU_ADD;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL rr_pre_valid: got %b expected 01", rsp_valid); end
        reset = 1'b1;
        req_a0 = 64'd2;  req_b0 = 64'd3; req_op0 = ALU_ADD;
        req_a1 = 64'd10; req_b1 = 64'd1; req_op1 = ALU_SUB;
        req_valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rr_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_data !== 64'd0) begin failures++; $display("FAIL rr_data: got %h expected 0", rsp_data); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rr_state: got %0d expected 0", dbg_state); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rr_ready_in_reset: got %b expected 00", req_ready); end
        reset = 1'b0;
        rsp_ready = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_first_grant: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL rr_after_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_data !== 64'd5) begin failures++; $display("FAIL rr_after_data: got %h expected %h", rsp_data, 64'd5); end
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_err_nor();
        test_drop();
        test_fairness();
        test_backpressure();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
